// File: rtl/sgpr_pkg.sv
// sgpr_pkg: shared constants and types for the SGPR read/write port logic.
//   SGPR_ADDR_W / SGPR_DEPTH / SGPR_DATA_W : geometry of the 128x32b SGPR array
//   rd_state_e                             : read-port sequencer state
package sgpr_pkg;

    localparam int SGPR_ADDR_W = 7;
    localparam int SGPR_DEPTH  = 128;
    localparam int SGPR_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_LO = 2'd1,
        RD_HI = 2'd2
    } rd_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   valid   : request vector
//   ptr     : index where the priority search starts
//   en      : when low no grant is issued
//   gnt     : one-hot grant (all zero if no grant)
//   ptr_nxt : index after the winner (wraps); equals ptr when nothing is granted
// Kept free of SGPR specifics so the write port can reuse it.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   ptr_nxt
);

    logic found;
    int   idx;

    always_comb begin
        gnt     = '0;
        ptr_nxt = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            // Rotate the search so it begins at ptr; NUM_REQ need not be a power of two.
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (en && !found && valid[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                ptr_nxt  = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
    end

endmodule

// File: rtl/sgpr_rd_port_arbiter.sv
// sgpr_rd_port_arbiter: shares the single SGPR read port between NUM_REQ
// requesters with round-robin arbitration, sequencing 32-bit and 64-bit
// (addr, addr+1) reads and returning tagged data.
//   clk, rst      : clock, synchronous active-low reset
//   req_valid/addr/wide/tag : per-requester level requests (held until gnt)
//   req_gnt       : combinational one-hot acceptance
//   rd_sel        : registered select into the SGPR read mux
//   rd_data       : mux output (combinational from rd_sel)
//   rsp_valid/id/tag/data/err : single-cycle response pulse
// Build option: define SGPR_RD_WIDE_ALIGN_CHK_EN to flag wide reads on an odd
// base address (rsp_err=1, rsp_data=0). Without it rsp_err is tied low.
module sgpr_rd_port_arbiter
    import sgpr_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int ADDR_W  = SGPR_ADDR_W,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_wide,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    output logic [NUM_REQ-1:0]        req_gnt,
    output logic [ADDR_W-1:0]         rd_sel,
    input  logic [SGPR_DATA_W-1:0]    rd_data,
    output logic                      rsp_valid,
    output logic [IDW-1:0]            rsp_id,
    output logic [TAG_W-1:0]          rsp_tag,
    output logic [2*SGPR_DATA_W-1:0]  rsp_data,
    output logic                      rsp_err
);

    rd_state_e              st;
    logic [IDW-1:0]         rr_ptr;
    logic [IDW-1:0]         ptr_nxt;
    logic [ADDR_W-1:0]      cur_addr;
    logic                   cur_wide;
    logic [IDW-1:0]         cur_id;
    logic [TAG_W-1:0]       cur_tag;
    logic [SGPR_DATA_W-1:0] lo_data;

    logic                   gnt_en;
    logic                   any_gnt;
    logic                   final_cap;
    logic [NUM_REQ-1:0]     gnt;
    logic [IDW-1:0]         gnt_id;
    logic [ADDR_W-1:0]      gnt_addr;
    logic                   gnt_wide;
    logic [TAG_W-1:0]       gnt_tag;

    // Last read cycle of the current op: a new op can be accepted here so
    // narrow reads stream at one per cycle. Reset masks grants entirely.
    assign final_cap = (st == RD_HI) || (st == RD_LO && !cur_wide);
    assign gnt_en    = rst && ((st == IDLE) || final_cap);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (IDW)
    ) u_arb (
        .valid   (req_valid),
        .ptr     (rr_ptr),
        .en      (gnt_en),
        .gnt     (gnt),
        .ptr_nxt (ptr_nxt)
    );

    assign req_gnt = gnt;
    assign any_gnt = |gnt;

    // Select the winner's request fields.
    always_comb begin
        gnt_id   = '0;
        gnt_addr = '0;
        gnt_wide = 1'b0;
        gnt_tag  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_id   = IDW'(i);
                gnt_addr = req_addr[i*ADDR_W +: ADDR_W];
                gnt_wide = req_wide[i];
                gnt_tag  = req_tag[i*TAG_W +: TAG_W];
            end
        end
    end

`ifdef SGPR_RD_WIDE_ALIGN_CHK_EN
    logic align_err;
    assign align_err = cur_wide && cur_addr[0];
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            st        <= IDLE;
            rr_ptr    <= '0;
            cur_addr  <= '0;
            cur_wide  <= 1'b0;
            cur_id    <= '0;
            cur_tag   <= '0;
            lo_data   <= '0;
            rd_sel    <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            rsp_data  <= '0;
`ifdef SGPR_RD_WIDE_ALIGN_CHK_EN
            rsp_err   <= 1'b0;
`endif
        end else begin
            rsp_valid <= final_cap;

            // rd_sel is loaded one edge ahead so it only ever comes from flops.
            if (any_gnt) begin
                rr_ptr   <= ptr_nxt;
                cur_addr <= gnt_addr;
                cur_wide <= gnt_wide;
                cur_id   <= gnt_id;
                cur_tag  <= gnt_tag;
                rd_sel   <= gnt_addr;
            end

            case (st)
                IDLE: begin
                    if (any_gnt) st <= RD_LO;
                end
                RD_LO: begin
                    lo_data <= rd_data;
                    if (cur_wide) begin
                        st     <= RD_HI;
                        rd_sel <= cur_addr + ADDR_W'(1); // wraps 127 -> 0
                    end else begin
                        st <= any_gnt ? RD_LO : IDLE;
                    end
                end
                RD_HI: begin
                    st <= any_gnt ? RD_LO : IDLE;
                end
                default: st <= IDLE;
            endcase

            // All response fields update together on the final capture edge.
            if (final_cap) begin
                rsp_id  <= cur_id;
                rsp_tag <= cur_tag;
`ifdef SGPR_RD_WIDE_ALIGN_CHK_EN
                rsp_err <= align_err;
                if (align_err)
                    rsp_data <= '0;
                else
`endif
                if (st == RD_HI)
                    rsp_data <= {rd_data, lo_data};
                else
                    rsp_data <= {{SGPR_DATA_W{1'b0}}, rd_data};
            end
        end
    end

endmodule

// File: tb/tb_sgpr_rd_port_arbiter.sv
// tb_sgpr_rd_port_arbiter: directed bench for sgpr_rd_port_arbiter.
// The SGPR mux is modelled as mem[a] = 0xA5A5_0000 | a.
module tb_sgpr_rd_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [27:0] req_addr;
    logic [3:0]  req_wide;
    logic [15:0] req_tag;
    logic [3:0]  req_gnt;
    logic [6:0]  rd_sel;
    logic [31:0] rd_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_data;
    logic        rsp_err;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    assign rd_data = 32'hA5A5_0000 | 32'(rd_sel);

    sgpr_rd_port_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_wide  (req_wide),
        .req_tag   (req_tag),
        .req_gnt   (req_gnt),
        .rd_sel    (rd_sel),
        .rd_data   (rd_data),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err)
    );

    task automatic chk(input string tg, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tg, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [6:0] a,
                           input logic w, input logic [3:0] t);
        req_valid[i]       = v;
        req_addr[i*7 +: 7] = a;
        req_wide[i]        = w;
        req_tag[i*4 +: 4]  = t;
    endtask

    function automatic logic [31:0] mem(input int a);
        return 32'hA5A5_0000 | 32'(a & 127);
    endfunction

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 7'(16 + i), 1'b0, 4'(8 + i));

        // Reset held with everyone requesting
        repeat (3) nxt();
        @(negedge clk);
        chk("rst_gnt", 64'(req_gnt), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        chk("rst_rd_sel", 64'(rd_sel), 64'h0);
        chk("rst_rsp_data", rsp_data, 64'h0);
        nxt();
        rst = 1'b1;

        // Fairness: continuous narrow requests from all four
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("fair_gnt%0d", c), 64'(req_gnt), 64'(1 << (c % 4)));
            if (c >= 1) chk($sformatf("fair_sel%0d", c), 64'(rd_sel), 64'(16 + (c - 1) % 4));
            chk($sformatf("fair_vld%0d", c), 64'(rsp_valid), 64'(c >= 2));
            if (c >= 2) begin
                chk($sformatf("fair_id%0d", c), 64'(rsp_id), 64'((c - 2) % 4));
                chk($sformatf("fair_tag%0d", c), 64'(rsp_tag), 64'(8 + (c - 2) % 4));
                chk($sformatf("fair_data%0d", c), rsp_data, {32'h0, mem(16 + (c - 2) % 4)});
            end
            nxt();
        end
        req_valid = 4'b0;
        repeat (4) nxt();

        // Mixed: req0 wide @10 and req2 narrow @20 together (pointer at 0)
        set_req(0, 1'b1, 7'd10, 1'b1, 4'd2);
        set_req(2, 1'b1, 7'd20, 1'b0, 4'd5);
        @(negedge clk);
        chk("mix_gnt0", 64'(req_gnt), 64'h1);
        nxt();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mix_gnt_lo", 64'(req_gnt), 64'h0);
        chk("mix_sel10", 64'(rd_sel), 64'd10);
        nxt();
        @(negedge clk);
        chk("mix_gnt2", 64'(req_gnt), 64'h4);
        chk("mix_sel11", 64'(rd_sel), 64'd11);
        chk("mix_vld_early", 64'(rsp_valid), 64'h0);
        nxt();
        req_valid[2] = 1'b0;
        @(negedge clk);
        chk("mix_sel20", 64'(rd_sel), 64'd20);
        chk("mix_vld0", 64'(rsp_valid), 64'h1);
        chk("mix_id0", 64'(rsp_id), 64'd0);
        chk("mix_tag0", 64'(rsp_tag), 64'd2);
        chk("mix_data0", rsp_data, {mem(11), mem(10)});
        chk("mix_err0", 64'(rsp_err), 64'h0);
        nxt();
        @(negedge clk);
        chk("mix_vld2", 64'(rsp_valid), 64'h1);
        chk("mix_id2", 64'(rsp_id), 64'd2);
        chk("mix_tag2", 64'(rsp_tag), 64'd5);
        chk("mix_data2", rsp_data, {32'h0, mem(20)});
        nxt();
        @(negedge clk);
        chk("mix_vld_end", 64'(rsp_valid), 64'h0);
        repeat (2) nxt();

        // Single narrow read: req0 @5 tag 3 (pointer at 3, wraps to 0)
        set_req(0, 1'b1, 7'd5, 1'b0, 4'd3);
        @(negedge clk);
        chk("nar_gnt", 64'(req_gnt), 64'h1);
        nxt();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("nar_sel", 64'(rd_sel), 64'd5);
        chk("nar_vld_early", 64'(rsp_valid), 64'h0);
        nxt();
        @(negedge clk);
        chk("nar_vld", 64'(rsp_valid), 64'h1);
        chk("nar_id", 64'(rsp_id), 64'd0);
        chk("nar_tag", 64'(rsp_tag), 64'd3);
        chk("nar_data", rsp_data, 64'h0000_0000_A5A5_0005);
        nxt();
        @(negedge clk);
        chk("nar_pulse", 64'(rsp_valid), 64'h0);
        chk("nar_sel_hold", 64'(rd_sel), 64'd5);
        nxt();

        // Wide read with wrap: req1 @127
        set_req(1, 1'b1, 7'd127, 1'b1, 4'hC);
        @(negedge clk);
        chk("wrap_gnt", 64'(req_gnt), 64'h2);
        nxt();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("wrap_sel127", 64'(rd_sel), 64'd127);
        nxt();
        @(negedge clk);
        chk("wrap_sel0", 64'(rd_sel), 64'd0);
        chk("wrap_vld_early", 64'(rsp_valid), 64'h0);
        nxt();
        @(negedge clk);
        chk("wrap_vld", 64'(rsp_valid), 64'h1);
        chk("wrap_id", 64'(rsp_id), 64'd1);
        chk("wrap_tag", 64'(rsp_tag), 64'hC);
`ifdef SGPR_RD_WIDE_ALIGN_CHK_EN
        chk("wrap_err", 64'(rsp_err), 64'h1);
        chk("wrap_data", rsp_data, 64'h0);
`else
        chk("wrap_err", 64'(rsp_err), 64'h0);
        chk("wrap_data", rsp_data, {mem(0), mem(127)});
`endif
        nxt();

        // Mid-op reset during RD_HI (pointer at 2, req0 wins after wrap)
        set_req(0, 1'b1, 7'd40, 1'b1, 4'd7);
        @(negedge clk);
        chk("mrst_gnt", 64'(req_gnt), 64'h1);
        nxt();
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("mrst_sel40", 64'(rd_sel), 64'd40);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_sel41", 64'(rd_sel), 64'd41);
        chk("mrst_gnt_masked", 64'(req_gnt), 64'h0);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_no_rsp", 64'(rsp_valid), 64'h0);
        chk("mrst_sel0", 64'(rd_sel), 64'd0);
        // Pointer must be back at 0 and FSM idle: req0 wins immediately
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 7'(16 + i), 1'b0, 4'(8 + i));
        #1;
        chk("mrst_ptr0", 64'(req_gnt), 64'h1);
        nxt();
        req_valid = 4'b0;
        @(negedge clk);
        chk("mrst_no_rsp2", 64'(rsp_valid), 64'h0);
        chk("mrst_sel16", 64'(rd_sel), 64'd16);
        nxt();
        @(negedge clk);
        chk("mrst_rsp", 64'(rsp_valid), 64'h1);
        chk("mrst_rsp_id", 64'(rsp_id), 64'd0);
        chk("mrst_rsp_data", rsp_data, {32'h0, mem(16)});
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sgpr_rd_port_arbiter.md
Name: sgpr_rd_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single SGPR read port (7-bit select into the 128x32b read mux) between NUM_REQ requesters (SALU, SIMD, SIMF, LSU).
- Accepts 32-bit and 64-bit (even/odd pair) read requests, drives the mux select, captures the mux output and returns tagged data to the winning requester.
- Sits between the issue/exec units and the SGPR array read mux.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TAG_W, 4, width of the request tag echoed with the response
- ADDR_W, 7, SGPR address width (128 entries)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- req_valid  in  NUM_REQ  per-requester request valid
- req_addr  in  NUM_REQ*ADDR_W  per-requester base SGPR address, packed, requester i at [i*ADDR_W +: ADDR_W]
- req_wide  in  NUM_REQ  1 = 64-bit read (addr, addr+1)
- req_tag  in  NUM_REQ*TAG_W  per-requester tag, packed
- req_gnt  out  NUM_REQ  one-hot acceptance pulse
- rd_sel  out  ADDR_W  select to the SGPR read mux
- rd_data  in  32  mux output, combinational from rd_sel
- rsp_valid  out  1  response valid, single-cycle pulse
- rsp_id  out  $clog2(NUM_REQ)  requester index of the response
- rsp_tag  out  TAG_W  echoed tag
- rsp_data  out  64  [31:0] = addr, [63:32] = addr+1 (upper half zero for 32-bit reads)
- rsp_err  out  1  see Optional Feature; tied 0 when the feature is compiled out

Behaviour:
- Reset (rst==0 at posedge): FSM=IDLE, rr pointer=0, req_gnt=0, rd_sel=0, rsp_valid=0, rsp_id=0, rsp_tag=0, rsp_data=0, rsp_err=0.
- Requests are level; a requester holds valid/addr/wide/tag until it sees its req_gnt bit high.
- req_gnt is combinational and at most one-hot. It is issued only when FSM is IDLE or in the final read cycle (RD_LO of a narrow read, RD_HI of a wide read). This gives back-to-back 32-bit reads at 1 per cycle.
- Round-robin: search starts at rr pointer. After a grant to requester k, the pointer becomes (k+1) mod NUM_REQ. No grant leaves the pointer unchanged.
- On grant, the block registers addr, wide, id and tag, and moves to RD_LO.
- States:
  - IDLE: rd_sel holds its last value.
  - RD_LO: rd_sel=addr; rd_data captured into rsp_data[31:0] at the clock edge. Next state is RD_HI if wide, else one of: RD_LO (new grant), IDLE (no grant).
  - RD_HI: rd_sel=addr+1 (modulo 128; addr 127 wraps to 0); rd_data captured into rsp_data[63:32]. Next state is RD_LO on a new grant, else IDLE.
- rd_sel is driven from registered state only, so there is no combinational path from req_* to rd_sel.
- Latency, grant at cycle t:
  - 32-bit: rsp_valid at t+2.
  - 64-bit: rsp_valid at t+3.
  - The response registers update in the same edge as the final capture.
- Responses are in grant order; there is no backpressure on rsp.
- For 32-bit reads, rsp_data[63:32]=0.
- Reset asserted mid-sequence aborts the read: no rsp_valid is issued and in-flight state is discarded.
- Simultaneous requests: exactly one grant, chosen per the pointer. Losers keep requesting.

Optional Feature:
- Macro SGPR_RD_WIDE_ALIGN_CHK_EN.
- Defined: a wide request with odd addr is still granted and read as normal (addr, addr+1 with wrap), but its response carries rsp_err=1 and rsp_data=0.
- Undefined: no check; rsp_err=0 always; odd-based wide reads return data normally.

Decomposition:
- Shared package sgpr_pkg holds: SGPR_ADDR_W=7, SGPR_DEPTH=128, SGPR_DATA_W=32, and a typedef for FSM state {IDLE, RD_LO, RD_HI}.
- One sub-module: rr_arbiter (parameterised NUM_REQ, inputs valid vector, pointer and enable; outputs one-hot grant and next pointer). It is reusable for the SGPR write port.

Test Plan:
- Reset: hold rst=0 3 cycles with all req_valid=1 -> req_gnt=0, rsp_valid=0, rd_sel=0; the first grant after release goes to requester 0.
- Single narrow read: req0 addr=5, tag=3, mux model returns 0xA5A5_0005 -> gnt at t, rd_sel=5 at t+1, rsp_valid at t+2 with id=0, tag=3, data=0x0000_0000_A5A5_0005.
- Wide read with wrap: req1 wide addr=127 -> rd_sel 127 then 0; rsp at t+3, data={mem[0],mem[127]}. With SGPR_RD_WIDE_ALIGN_CHK_EN defined: rsp_err=1, data=0.
- Fairness: all 4 requesting continuously with narrow reads -> grant order 0,1,2,3,0,...; one rsp per cycle in the same order.
- Mixed: req0 wide addr=10, req2 narrow addr=20 simultaneously -> rd_sel sequence 10,11,20; rsp id0 at t+3, id2 at t+4.
- Mid-op reset: assert rst=0 during RD_HI -> no rsp_valid; after release, the FSM is in IDLE and the pointer is 0.
